// File: rtl/instr_fetch_unit.sv
// Fetch stage ahead of asyn_controller: walks the PC through instruction memory
// over a req/ack handshake and queues returned words for the controller.
module instr_fetch_unit #(
    parameter int                XLEN       = 32,
    parameter logic [XLEN-1:0]   RESET_PC   = '0,
    parameter int                IBUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode,
    output logic            illegal
);

    localparam int              PW      = $clog2(IBUF_DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(IBUF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DISCARD
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_addr;
    logic              r_req;
    logic [PW-1:0]     r_wrPtr;
    logic [PW-1:0]     r_rdPtr;
    logic [CW-1:0]     r_count;
    logic [31:0]       r_instrMem [IBUF_DEPTH];
    logic [XLEN-1:0]   r_pcMem    [IBUF_DEPTH];

    logic              w_ack;
    logic              w_push;
    logic              w_pop;
    logic [CW-1:0]     w_countNext;
    logic [XLEN-1:0]   w_redirPc;
    logic [XLEN-1:0]   w_pcPlus4;

    assign w_ack       = r_req && imem_ack;
    assign w_push      = (r_state == S_REQ) && w_ack && !redirect;
    assign w_pop       = instr_valid && instr_ready;
    assign w_countNext = r_count + CW'(w_push) - CW'(w_pop);
    assign w_redirPc   = redirect_pc & ~XLEN'(3);
    assign w_pcPlus4   = r_pc + XLEN'(4);

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;

    assign instr_valid = (r_count != '0);
    assign instr       = instr_valid ? r_instrMem[r_rdPtr] : '0;
    assign instr_pc    = instr_valid ? r_pcMem[r_rdPtr] : '0;
    assign opcode      = instr[6:0];
    assign illegal     = instr_valid && (instr[1:0] != 2'b11);

    // Buffer storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instrMem[r_wrPtr] <= imem_rdata;
            r_pcMem[r_wrPtr]    <= r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_req   <= 1'b0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (redirect) begin
                r_wrPtr <= '0;
                r_rdPtr <= '0;
                r_count <= '0;
                r_pc    <= w_redirPc;
            end else begin
                if (w_push) begin
                    r_wrPtr <= r_wrPtr + PW'(1);
                    r_pc    <= w_pcPlus4;
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + PW'(1);
                end
                r_count <= w_countNext;
            end

            // A redirect while a request is pending must still wait out its ack.
            case (r_state)
                S_IDLE: begin
                    if (!redirect && (r_count < DEPTH_C)) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_addr  <= r_pc;
                    end
                end
                S_REQ: begin
                    if (redirect) begin
                        if (w_ack) begin
                            r_state <= S_IDLE;
                            r_req   <= 1'b0;
                        end else begin
                            r_state <= S_DISCARD;
                        end
                    end else if (w_ack) begin
                        if (w_countNext < DEPTH_C) begin
                            r_addr <= w_pcPlus4;
                        end else begin
                            r_state <= S_IDLE;
                            r_req   <= 1'b0;
                        end
                    end
                end
                S_DISCARD: begin
                    if (!redirect && w_ack) begin
                        r_state <= S_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a latency-programmable memory model feeds
// the DUT and every accepted fetch is queued and compared against delivered instructions.
module tb_instr_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic        illegal;

    int          checks   = 0;
    int          failures = 0;

    entry_t      sbQ[$];
    logic [31:0] modelPc;
    bit          discard;
    int          waitCnt;
    int          ackDelay;
    bit          readyVal;
    bit          redirNow;
    logic [31:0] redirPcVal;
    bit          prevPending;
    logic [31:0] prevAddr;
    int          ackCount;
    bit          seenPc100;
    bit          seenPc200;
    bit          seenIllegal;
    bit          seenWrapZero;

    instr_fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .IBUF_DEPTH (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .opcode      (opcode),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Instruction memory contents: address 0 and the top word are pinned for the wrap/illegal cases.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0000_0000)      return 32'h0000_2003;
        else if (a == 32'hFFFF_FFFC) return 32'h0000_0000;
        else                         return {a[24:0], 7'b0010011};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // One clock of stimulus, entered and left at a falling edge.
    task automatic applyStimulus();
        entry_t e;
        bit     ackNow;
        bit     popNow;
        checkOutput("valid", {31'b0, instr_valid}, {31'b0, (sbQ.size() != 0)});
        if (!instr_valid) begin
            checkOutput("idle_instr", instr, 32'h0);
            checkOutput("idle_pc", instr_pc, 32'h0);
            checkOutput("idle_op_ill", {24'b0, opcode, illegal}, 32'h0);
        end
        if (prevPending) begin
            checkOutput("req_hold", {31'b0, imem_req}, 32'h1);
            checkOutput("addr_hold", imem_addr, prevAddr);
        end
        instr_ready = readyVal;
        ackNow      = imem_req && (waitCnt >= ackDelay);
        imem_ack    = ackNow;
        imem_rdata  = ackNow ? memWord(imem_addr) : $urandom();
        redirect    = redirNow;
        redirect_pc = redirNow ? redirPcVal : $urandom();
        popNow      = instr_valid && readyVal;
        if (popNow && sbQ.size() != 0) begin
            e = sbQ.pop_front();
            checkOutput("pop_instr", instr, e.word);
            checkOutput("pop_pc", instr_pc, e.pc);
            checkOutput("pop_opcode", {25'b0, opcode}, {25'b0, e.word[6:0]});
            checkOutput("pop_illegal", {31'b0, illegal}, {31'b0, (e.word[1:0] != 2'b11)});
            if (e.pc == 32'h100) seenPc100 = 1;
            if (e.pc == 32'h200) seenPc200 = 1;
            if (e.word[1:0] != 2'b11) seenIllegal = 1;
            if (seenIllegal && e.pc == 32'h0) seenWrapZero = 1;
        end
        if (ackNow)        waitCnt = 0;
        else if (imem_req) waitCnt++;
        else               waitCnt = 0;
        if (redirNow) begin
            sbQ.delete();
            modelPc = redirPcVal & ~32'h3;
            discard = discard || (imem_req && !ackNow);
        end else if (ackNow) begin
            if (discard) begin
                discard = 0;
            end else begin
                checkOutput("fetch_addr", imem_addr, modelPc);
                sbQ.push_back('{pc: modelPc, word: memWord(modelPc)});
                modelPc = modelPc + 32'd4;
                ackCount++;
            end
        end
        prevPending = imem_req && !ackNow;
        prevAddr    = imem_addr;
        redirNow    = 0;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset is raised with ack held high to show an in-flight response is ignored.
    task automatic applyReset();
        reset       = 1'b1;
        imem_ack    = 1'b1;
        imem_rdata  = $urandom();
        redirect    = 1'b0;
        instr_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req", {31'b0, imem_req}, 32'h0);
        checkOutput("rst_addr", imem_addr, 32'h0);
        checkOutput("rst_valid", {31'b0, instr_valid}, 32'h0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_pc", instr_pc, 32'h0);
        checkOutput("rst_op_ill", {24'b0, opcode, illegal}, 32'h0);
        reset       = 1'b0;
        imem_ack    = 1'b0;
        sbQ.delete();
        modelPc     = 32'h0;
        discard     = 0;
        waitCnt     = 0;
        prevPending = 0;
        ackCount    = 0;
        applyStimulus();
        checkOutput("start_req", {31'b0, imem_req}, 32'h1);
        checkOutput("start_addr", imem_addr, 32'h0);
    endtask

    initial begin
        bit found;
        int startAcks;
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        redirNow    = 0;
        redirPcVal  = '0;
        seenPc100   = 0;
        seenPc200   = 0;
        seenIllegal = 0;
        seenWrapZero = 0;
        @(negedge clk);

        // Straight-line fetch at one instruction per cycle.
        readyVal = 1;
        ackDelay = 0;
        applyReset();
        repeat (2) applyStimulus();
        startAcks = ackCount;
        repeat (6) applyStimulus();
        checkOutput("throughput", ackCount - startAcks, 32'd6);

        // Backpressure fills the two-entry buffer and stalls requests.
        readyVal = 0;
        applyReset();
        repeat (10) applyStimulus();
        checkOutput("bp_req", {31'b0, imem_req}, 32'h0);
        checkOutput("bp_acks", ackCount, 32'd2);
        checkOutput("bp_head", instr_pc, 32'h0);
        readyVal = 1;
        repeat (8) applyStimulus();

        // Slow memory: three-cycle ack delay.
        ackDelay = 3;
        applyReset();
        repeat (20) applyStimulus();
        checkOutput("slow_acks", {31'b0, (ackCount >= 4)}, 32'h1);

        // Redirect while the request for 0x8 waits on memory.
        applyReset();
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (imem_req && imem_addr == 32'h8 && waitCnt == 1) found = 1;
            else applyStimulus();
        end
        checkOutput("wait_addr8", {31'b0, found}, 32'h1);
        redirNow   = 1;
        redirPcVal = 32'h100;
        applyStimulus();
        checkOutput("redir_flush", {31'b0, instr_valid}, 32'h0);
        repeat (30) applyStimulus();
        checkOutput("redir_seen100", {31'b0, seenPc100}, 32'h1);

        // Redirect colliding with an ack and a pop while one entry is buffered.
        ackDelay = 0;
        applyReset();
        repeat (5) applyStimulus();
        checkOutput("coll_valid", {31'b0, instr_valid}, 32'h1);
        checkOutput("coll_req", {31'b0, imem_req}, 32'h1);
        redirNow   = 1;
        redirPcVal = 32'h200;
        applyStimulus();
        checkOutput("coll_flush", {31'b0, instr_valid}, 32'h0);
        repeat (10) applyStimulus();
        checkOutput("coll_seen200", {31'b0, seenPc200}, 32'h1);

        // Wrap from the top of the address space; low redirect bits are ignored.
        redirNow   = 1;
        redirPcVal = 32'hFFFF_FFFF;
        applyStimulus();
        repeat (10) applyStimulus();
        checkOutput("wrap_illegal", {31'b0, seenIllegal}, 32'h1);
        checkOutput("wrap_zero", {31'b0, seenWrapZero}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
